// File: rtl/spi_ram_master.sv
// Host-side SPI master: each command is sent as two 10-bit frames {cmd,payload}, and a read also captures 8 MISO bits.
// Latency is fixed by DIV, GAP_CYC and TURN. A start while busy (including the done cycle) is dropped.
module spi_ram_master #(
   parameter int DIV     = 2,
   parameter int GAP_CYC = 4,
   parameter int TURN    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rd_wr,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sck,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);
   localparam int MAXC = (DIV > GAP_CYC) ? DIV : GAP_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [3:0]    TURN_LAST = 4'(TURN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_SHIFT, S_TURNA, S_RECV, S_HOLD, S_GAP, S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          ph, ph_nx;         // 0 = sck-high half of a bit, 1 = sck-low half
   logic [3:0]    bit_cnt, bit_nx;
   logic          second, second_nx;
   logic          is_rd, is_rd_nx;
   logic [7:0]    wdata_q, wdata_nx;
   logic [9:0]    tx_sr, tx_nx;
   logic [7:0]    rx_sr, rx_nx;
   logic          sck_nx, ss_n_nx, mosi_nx, busy_nx, done_nx;
   logic [7:0]    rdata_nx;
   logic          half_end;
   logic [9:0]    frame2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         ph      <= 1'b0;
         bit_cnt <= '0;
         second  <= 1'b0;
         is_rd   <= 1'b0;
         wdata_q <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sck     <= 1'b0;
         ss_n    <= 1'b1;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         ph      <= ph_nx;
         bit_cnt <= bit_nx;
         second  <= second_nx;
         is_rd   <= is_rd_nx;
         wdata_q <= wdata_nx;
         tx_sr   <= tx_nx;
         rx_sr   <= rx_nx;
         sck     <= sck_nx;
         ss_n    <= ss_n_nx;
         mosi    <= mosi_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         rdata   <= rdata_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ph_nx     = ph;
      bit_nx    = bit_cnt;
      second_nx = second;
      is_rd_nx  = is_rd;
      wdata_nx  = wdata_q;
      tx_nx     = tx_sr;
      rx_nx     = rx_sr;
      sck_nx    = sck;
      ss_n_nx   = ss_n;
      mosi_nx   = mosi;
      busy_nx   = busy;
      done_nx   = 1'b0;
      rdata_nx  = rdata;
      half_end  = (cnt == HALF_LAST);
      frame2    = {(is_rd ? 2'b11 : 2'b01), (is_rd ? 8'h00 : wdata_q)};

      // The half-period counter free-runs while a frame is on the wire
      if (state inside {S_ASSERT, S_SHIFT, S_TURNA, S_RECV, S_HOLD})
         cnt_nx = half_end ? '0 : cnt + 1'b1;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx  = S_ASSERT;
               busy_nx   = 1'b1;
               is_rd_nx  = rd_wr;
               wdata_nx  = wdata;
               second_nx = 1'b0;
               cnt_nx    = '0;
               tx_nx     = {rd_wr, 1'b0, addr};
               ss_n_nx   = 1'b0;
               mosi_nx   = rd_wr;
            end
         end
         S_ASSERT: begin
            if (half_end) begin
               state_nx = S_SHIFT;
               sck_nx   = 1'b1;
               ph_nx    = 1'b0;
               bit_nx   = 4'd9;
            end
         end
         S_SHIFT: begin
            if (half_end) begin
               if (!ph) begin
                  // Falling edge: present the next bit; zeros trail after bit 0
                  sck_nx  = 1'b0;
                  ph_nx   = 1'b1;
                  mosi_nx = tx_sr[8];
                  tx_nx   = {tx_sr[8:0], 1'b0};
               end else if (bit_cnt != 4'd0) begin
                  bit_nx = bit_cnt - 1'b1;
                  sck_nx = 1'b1;
                  ph_nx  = 1'b0;
               end else if (is_rd && second) begin
                  sck_nx = 1'b1;
                  ph_nx  = 1'b0;
                  if (TURN > 0) begin
                     state_nx = S_TURNA;
                     bit_nx   = TURN_LAST;
                  end else begin
                     state_nx = S_RECV;
                     bit_nx   = 4'd7;
                     rx_nx    = {rx_sr[6:0], miso};
                  end
               end else begin
                  state_nx = S_HOLD;
               end
            end
         end
         S_TURNA: begin
            if (half_end) begin
               if (!ph) begin
                  sck_nx = 1'b0;
                  ph_nx  = 1'b1;
               end else if (bit_cnt != 4'd0) begin
                  bit_nx = bit_cnt - 1'b1;
                  sck_nx = 1'b1;
                  ph_nx  = 1'b0;
               end else begin
                  state_nx = S_RECV;
                  bit_nx   = 4'd7;
                  sck_nx   = 1'b1;
                  ph_nx    = 1'b0;
                  rx_nx    = {rx_sr[6:0], miso};
               end
            end
         end
         S_RECV: begin
            if (half_end) begin
               if (!ph) begin
                  sck_nx = 1'b0;
                  ph_nx  = 1'b1;
               end else if (bit_cnt != 4'd0) begin
                  bit_nx = bit_cnt - 1'b1;
                  sck_nx = 1'b1;
                  ph_nx  = 1'b0;
                  rx_nx  = {rx_sr[6:0], miso};
               end else begin
                  state_nx = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (half_end) begin
               ss_n_nx = 1'b1;
               if (!second) begin
                  state_nx = S_GAP;
               end else begin
                  state_nx = S_DONE;
                  done_nx  = 1'b1;
                  if (is_rd)
                     rdata_nx = rx_sr;
               end
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nx  = S_ASSERT;
               cnt_nx    = '0;
               second_nx = 1'b1;
               tx_nx     = frame2;
               mosi_nx   = frame2[9];
               ss_n_nx   = 1'b0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_DONE: begin
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (DIV=2/GAP=4 and DIV=1/GAP=1) share one muxed SPI slave+RAM model.
// Expected frames and done results are queued at issue time and compared by a single negedge monitor.
module tb_spi_ram_master;
   localparam int TURN = 1;

   typedef struct {
      int         start_cyc;
      int         lat;
      logic [7:0] rd;
   } dexp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start_a, start_b, rd_wr, miso, sel, final_req;
   logic [7:0] addr, wdata;
   logic       busy_a, done_a, sck_a, ss_n_a, mosi_a;
   logic       busy_b, done_b, sck_b, ss_n_b, mosi_b;
   logic [7:0] rdata_a, rdata_b;
   logic       sck_m, ss_n_m, mosi_m, busy_m, done_m;
   logic [7:0] rdata_m;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   int         tmo_cnt = 0;
   int         tmo_seen = 0;

   dexp_t      dq[$];
   logic [9:0] fq[$];
   logic [9:0] got_q[$];

   spi_ram_master #(.DIV(2), .GAP_CYC(4), .TURN(TURN)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rd_wr(rd_wr), .addr(addr), .wdata(wdata),
      .busy(busy_a), .done(done_a), .rdata(rdata_a), .sck(sck_a), .ss_n(ss_n_a),
      .mosi(mosi_a), .miso(miso)
   );

   spi_ram_master #(.DIV(1), .GAP_CYC(1), .TURN(TURN)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rd_wr(rd_wr), .addr(addr), .wdata(wdata),
      .busy(busy_b), .done(done_b), .rdata(rdata_b), .sck(sck_b), .ss_n(ss_n_b),
      .mosi(mosi_b), .miso(miso)
   );

   assign sck_m   = sel ? sck_b   : sck_a;
   assign ss_n_m  = sel ? ss_n_b  : ss_n_a;
   assign mosi_m  = sel ? mosi_b  : mosi_a;
   assign busy_m  = sel ? busy_b  : busy_a;
   assign done_m  = sel ? done_b  : done_a;
   assign rdata_m = sel ? rdata_b : rdata_a;

   always @(posedge clk) cyc <= cyc + 1;

   // SPI slave + RAM: samples MOSI on sck rise, drives MISO on sck fall after the turnaround
   logic       p_sck_s = 1'b0;
   int         s_bits = 0;
   logic [9:0] s_sr;
   logic [7:0] s_addr, s_tx;
   logic       s_rd = 1'b0;
   logic [7:0] ram [0:255];

   always @(sck_m or ss_n_m) begin
      if (ss_n_m !== 1'b0) begin
         s_bits = 0;
         s_rd   = 1'b0;
         miso   = 1'b0;
      end else if (sck_m && !p_sck_s) begin
         s_sr   = {s_sr[8:0], mosi_m};
         s_bits = s_bits + 1;
         if (s_bits == 10) begin
            got_q.push_back(s_sr);
            case (s_sr[9:8])
               2'b01:   ram[s_addr] = s_sr[7:0];
               2'b11:   begin s_tx = ram[s_addr]; s_rd = 1'b1; end
               default: s_addr = s_sr[7:0];
            endcase
         end
      end else if (!sck_m && p_sck_s && s_rd && s_bits >= 10 + TURN && s_bits < 18 + TURN) begin
         miso = s_tx[3'(7 - (s_bits - 10 - TURN))];
      end
      p_sck_s = sck_m;
   end

   task automatic chk(input string nm, input int act, input int req);
      checks = checks + 1;
      if (act != req) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_busy_a", busy_a, 0);  chk("rst_done_a", done_a, 0);
      chk("rst_sck_a", sck_a, 0);    chk("rst_ss_n_a", ss_n_a, 1);
      chk("rst_mosi_a", mosi_a, 0);  chk("rst_rdata_a", rdata_a, 0);
      chk("rst_busy_b", busy_b, 0);  chk("rst_sck_b", sck_b, 0);
      chk("rst_ss_n_b", ss_n_b, 1);  chk("rst_rdata_b", rdata_b, 0);
   endtask

   // Monitor: scoreboard pops, SPI protocol rules, reset values
   logic p_rst = 1'b0, p_sck = 1'b0, p_ss_n = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;
   int   hi_run = 100;
   int   last_rise = -1;

   always @(negedge clk) begin
      dexp_t      e;
      logic [9:0] f;
      if (rst && !p_rst)
         chk_reset_vals();
      while (got_q.size() > 0) begin
         f = got_q.pop_front();
         if (fq.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL extra_frame: got 0x%0h, required no frame", f);
         end else begin
            chk("frame", f, fq.pop_front());
         end
      end
      if (done_m) begin
         if (dq.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL extra_done: got done=1, required 0 (cycle %0d)", cyc);
         end else begin
            e = dq.pop_front();
            chk("done_latency", cyc - e.start_cyc, e.lat);
            chk("rdata", rdata_m, e.rd);
         end
      end
      if (!rst && !p_rst) begin
         if (sck_m != p_sck)   chk("sck_toggle_ss_hi", ss_n_m & p_ss_n, 0);
         if (ss_n_m != p_ss_n) chk("ss_change_sck_hi", sck_m | p_sck, 0);
         if (mosi_m != p_mosi) chk("mosi_change_sck_hi", sck_m, 0);
         if (!ss_n_m && p_ss_n && p_busy) chk("ss_gap", hi_run, sel ? 1 : 4);
         if (sck_m && !p_sck) begin
            if (last_rise >= 0) chk("sck_period", cyc - last_rise, sel ? 2 : 4);
            last_rise = cyc;
         end
      end
      if (ss_n_m) begin
         hi_run    = hi_run + 1;
         last_rise = -1;
      end else begin
         hi_run = 0;
      end
      if (tmo_cnt != tmo_seen) begin
         checks   = checks + 1;
         errors   = errors + 1;
         $display("FAIL wait_timeout: got %0d outstanding waits, required 0", tmo_cnt - tmo_seen);
         tmo_seen = tmo_cnt;
      end
      p_rst  = rst;
      p_sck  = sck_m;
      p_ss_n = ss_n_m;
      p_mosi = mosi_m;
      p_busy = busy_m;
      if (final_req) begin
         chk("frames_left", fq.size(), 0);
         chk("dones_left", dq.size(), 0);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic issue(input logic b, input logic rd, input logic [7:0] a, input logic [7:0] d,
                        input logic [9:0] f1, input logic [9:0] f2, input int lat,
                        input logic [7:0] exp_rd);
      dexp_t e;
      fq.push_back(f1);
      fq.push_back(f2);
      e.start_cyc = cyc + 1;
      e.lat       = lat;
      e.rd        = exp_rd;
      dq.push_back(e);
      rd_wr = rd;
      addr  = a;
      wdata = d;
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((dq.size() != 0 || fq.size() != 0) && n < 1000) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 1000) begin
         tmo_cnt = tmo_cnt + 1;
         dq.delete();
         fq.delete();
      end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      dexp_t e2;
      int    s;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rd_wr = 1'b0;
      addr = 8'h00; wdata = 8'h00; sel = 1'b0; final_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(0, 0, 8'h3C, 8'hA5, 10'h03C, 10'h1A5, 92, 8'h00);
      wait_idle();
      issue(0, 1, 8'h3C, 8'h00, 10'h23C, 10'h300, 128, 8'hA5);
      wait_idle();

      // A second start while busy must not produce frames or a done
      issue(0, 0, 8'h10, 8'h5A, 10'h010, 10'h15A, 92, 8'hA5);
      repeat (30) @(negedge clk);
      start_a = 1'b1; rd_wr = 1'b1; addr = 8'h20;
      @(negedge clk);
      start_a = 1'b0;
      wait_idle();

      // Start held through done: the read is taken two cycles after the done edge
      s = cyc + 1;
      fq.push_back(10'h000); fq.push_back(10'h1FF);
      fq.push_back(10'h200); fq.push_back(10'h300);
      e2.start_cyc = s;      e2.lat = 92;  e2.rd = 8'hA5; dq.push_back(e2);
      e2.start_cyc = s + 94; e2.lat = 128; e2.rd = 8'hFF; dq.push_back(e2);
      start_a = 1'b1; rd_wr = 1'b0; addr = 8'h00; wdata = 8'hFF;
      @(negedge clk);
      rd_wr = 1'b1; wdata = 8'h00;
      repeat (94) @(negedge clk);
      start_a = 1'b0;
      wait_idle();

      // Reset in the middle of the first frame's shift phase
      start_a = 1'b1; rd_wr = 1'b1; addr = 8'h3C;
      @(negedge clk);
      start_a = 1'b0;
      repeat (19) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      sel = 1'b1;
      repeat (2) @(negedge clk);
      issue(1, 0, 8'h81, 8'h3C, 10'h081, 10'h13C, 45, 8'h00);
      wait_idle();
      issue(1, 1, 8'h81, 8'h00, 10'h281, 10'h300, 63, 8'h3C);
      wait_idle();

      final_req = 1'b1;
      repeat (10) @(negedge clk);
      $display("FAIL summary_not_reached: monitor did not finish");
      $fatal(1);
   end
endmodule
